pipe_stage_skid: RTL

//  Parametrised successor of the fixed ID/EX latch: generic pipeline stage register between any two MIPS stages.

---
 rtl/pipe_stage_skid.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Generic MIPS pipeline stage register with a valid/ready
//            handshake and a 2-entry skid buffer. It provides synchronous
//            flush, and it zeroes the control payload whenever the head
//            slot is a bubble.
//            Optional statistics counters are enabled by defining
//            PIPE_STAGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid #(
    parameter int DW    = 138,
    parameter int CW    = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [CW-1:0]    in_ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // State encodes how many entries are held: main register, then skid.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_in_ready;
    logic [DW-1:0] r_main_data;
    logic [CW-1:0] r_main_ctrl;
    logic [DW-1:0] r_skid_data;
    logic [CW-1:0] r_skid_ctrl;
    logic          w_in_xfer;
    logic          w_out_xfer;
    logic          w_load_main;
    logic          w_main_from_skid;
    logic          w_load_skid;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = (r_state != S_EMPTY) & out_ready;

    // State register; in_ready is registered from the next state so it never
    // depends combinationally on the downstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_FULL);
        end
    end

    // Next-state and datapath steering; flush overrides every other event.
    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_next_state = S_BUSY;
                        w_load_main  = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_in_xfer) begin
                        w_next_state = S_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out_xfer) begin
                        w_next_state = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        w_next_state     = S_BUSY;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_EMPTY;
                end
            endcase
        end
    end

    // Payload registers; the skid entry slides into main on the same edge that the head leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    // Outputs; a bubble forces control to zero so a killed slot cannot write state downstream.
    always_comb begin
        in_ready  = r_in_ready;
        out_valid = (r_state != S_EMPTY);
        out_data  = r_main_data;
        out_ctrl  = (r_state != S_EMPTY) ? r_main_ctrl : '0;
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [1:0]       w_live;
    logic [CNT_W:0]   w_flush_sum;

    assign w_live      = (r_state == S_FULL) ? 2'd2 : ((r_state == S_BUSY) ? 2'd1 : 2'd0);
    assign w_flush_sum = {1'b0, r_flush_cnt} + {{(CNT_W-1){1'b0}}, w_live};

    // Saturating counters for stall cycles and for live entries squashed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != S_EMPTY) && !out_ready && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (w_live != 2'd0)) begin
                r_flush_cnt <= (w_flush_sum > {1'b0, C_CNT_MAX}) ? C_CNT_MAX
                                                                 : w_flush_sum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire
